writeback_sched: RTL and testbench
==================================

Name: writeback_sched

Overview:
- Schedules the LC3 writeback stage's single register-file write port between two producers: execute results (ALU / PC / NPC) and memory-load results.
- Buffers execute results in a small FIFO, gives loads priority with anti-starvation, and drives the writeback-stage inputs (W_Control, aluout, pcout, npc, memout, enable_writeback, dr) from registers.
- Exports a read-after-write hazard stall for decode on sr1/sr2.

Parameters:
- EX_DEPTH, 2, execute-result FIFO depth (power of two, >=2)
- MAX_MEM_STREAK, 4, consecutive load grants allowed while the execute FIFO is non-empty (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute result offered
- ex_ready  out  1  execute result accepted this cycle when high with ex_valid
- ex_sel  in  2  source of execute result: 0 aluout, 2 pcout, 3 npc (1 illegal)
- ex_aluout  in  16  ALU result
- ex_pcout  in  16  PC-relative address result
- ex_npc  in  16  next-PC value
- ex_dr  in  3  destination register
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle when high with mem_valid
- mem_data  in  16  load data
- mem_dr  in  3  load destination register
- sr1, sr2  in  3 each  decode source registers
- sr1_use, sr2_use  in  1 each  source actually read
- stall  out  1  RAW hazard on an in-use source
- W_Control  out  2  writeback mux select: 0 aluout, 1 memout, 2 pcout, 3 npc
- aluout, pcout, npc, memout  out  16 each  writeback operands
- enable_writeback  out  1  one-cycle write strobe
- dr  out  3  writeback destination

Behaviour:
- Reset: W_Control=0, aluout=pcout=npc=memout=0, enable_writeback=0, dr=0. FIFO is emptied, streak counter cleared, stall=0.
- Reset asserted mid-operation discards all buffered and in-flight results; nothing is written back for them.
- FIFO:
  - ex_ready = !full, computed on state at the start of the cycle. No push when full, even if a pop occurs that cycle.
  - Push on ex_valid && ex_ready.
  - An entry stores ex_sel, all three operands and ex_dr.
- Arbitration, evaluated every cycle with the FIFO head as the execute candidate:
  - If the FIFO is non-empty and streak == MAX_MEM_STREAK: execute wins; mem_ready=0.
  - Otherwise mem_ready=1. A load wins if mem_valid; execute wins if the FIFO is non-empty; otherwise there is no winner.
- Streak counter:
  - Increments on a load grant while the FIFO is non-empty, saturating at MAX_MEM_STREAK.
  - Clears on an execute grant or whenever the FIFO is empty.
- Output registers, loaded at the clock edge:
  - Load winner: W_Control=1, memout=mem_data, dr=mem_dr, enable_writeback=1.
  - Execute winner: W_Control=ex_sel, aluout/pcout/npc from the entry, dr=entry dr, enable_writeback=1, FIFO pops.
  - No winner: enable_writeback=0; all other outputs hold their values.
- Latency: a load accepted at edge N has enable_writeback high in cycle N+1. An execute result accepted at edge N into an empty FIFO with no load contention writes back at edge N+1 and is visible in cycle N+2.
- Simultaneous push and pop on a non-full FIFO is allowed; occupancy is unchanged.
- Pointers wrap modulo EX_DEPTH.
- Illegal ex_sel=1: entry is accepted and written back with W_Control=0. Assertion flagged in simulation only.
- stall (combinational) is 1 iff (sr1_use && sr1 matches) || (sr2_use && sr2 matches) against any of:
  - a valid FIFO entry's dr,
  - dr while enable_writeback=1,
  - mem_dr while mem_valid=1.

Optional Feature:
- Macro WB_SCHED_BYPASS_EN.
- Defined: when the FIFO is empty, mem_valid=0 and ex_valid=1, the execute result goes straight to the output registers at that edge without entering the FIFO. Latency is 1 cycle, matching loads.
- Undefined: every execute result passes through the FIFO (2-cycle latency as above).

Test Plan:
- Reset with FIFO holding 2 entries, then release -> no enable_writeback for 2 cycles; all outputs 0; ex_ready=1.
- Single execute ex_sel=0, ex_aluout=16'h1234, ex_dr=3 -> cycle N+2: enable_writeback=1, W_Control=0, aluout=16'h1234, dr=3 for exactly one cycle (N+1 with WB_SCHED_BYPASS_EN).
- Same cycle: ex_valid (ex_sel=3, npc=16'h3001, dr=1) and mem_valid (data=16'hBEEF, dr=2) -> load writes first (W_Control=1, memout=16'hBEEF, dr=2), execute next cycle (W_Control=3, npc=16'h3001, dr=1).
- mem_valid held high with 1 execute pending, MAX_MEM_STREAK=4 -> 4 load writebacks, then mem_ready=0 for one cycle and the execute writes back, then loads resume.
- 3 back-to-back ex_valid with mem_valid continuously high -> ex_ready drops to 0 after 2 accepts; third held until a slot frees; no entry lost or duplicated.
- FIFO holds dr=5; sr1=5, sr1_use=1 -> stall=1. Same with sr1_use=0 -> stall=0. stall clears the cycle after the dr=5 write strobe.

Source files
------------

// File: rtl/writeback_sched.sv
// Writeback-port scheduler: buffers execute results, arbitrates against loads with
// anti-starvation, and flags RAW hazards for decode. Optional macro: WB_SCHED_BYPASS_EN.
package writeback_sched_pkg;
  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] npc;
    logic [2:0]  dr;
  } ex_entry_t;
endpackage

module writeback_sched
  import writeback_sched_pkg::*;
#(
  parameter int unsigned EX_DEPTH       = 2,
  parameter int unsigned MAX_MEM_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_sel,
  input  logic [15:0] ex_aluout,
  input  logic [15:0] ex_pcout,
  input  logic [15:0] ex_npc,
  input  logic [2:0]  ex_dr,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [15:0] mem_data,
  input  logic [2:0]  mem_dr,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic        sr1_use,
  input  logic        sr2_use,
  output logic        stall,
  output logic [1:0]  W_Control,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [15:0] npc,
  output logic [15:0] memout,
  output logic        enable_writeback,
  output logic [2:0]  dr
);

  localparam int unsigned PTR_W = $clog2(EX_DEPTH);
  localparam int unsigned CNT_W = $clog2(EX_DEPTH + 1);
  localparam int unsigned STK_W = $clog2(MAX_MEM_STREAK + 1);

  ex_entry_t        fifo_q [EX_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STK_W-1:0] streak;

  ex_entry_t in_entry;
  ex_entry_t head;
  logic      fifo_empty;
  logic      fifo_full;
  logic      force_ex;
  logic      mem_win;
  logic      ex_win;
  logic      bypass;
  logic      push;
  logic      pop;
  logic [7:0] busy;

  // Arbitration and handshake, all from start-of-cycle state
  always_comb begin
    in_entry   = '{sel: ex_sel, aluout: ex_aluout, pcout: ex_pcout, npc: ex_npc, dr: ex_dr};
    head       = fifo_q[rd_ptr];
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_W'(EX_DEPTH));
    force_ex   = !fifo_empty && (streak == STK_W'(MAX_MEM_STREAK));
    mem_win    = mem_valid && !force_ex;
    ex_win     = !mem_win && !fifo_empty;
`ifdef WB_SCHED_BYPASS_EN
    bypass     = fifo_empty && !mem_valid && ex_valid;
`else
    bypass     = 1'b0;
`endif
    push       = ex_valid && !fifo_full && !bypass;
    pop        = ex_win;
  end

  assign ex_ready  = !fifo_full;
  assign mem_ready = !force_ex;

  // Destination registers still owed a write: queued entries, the live strobe, an offered load
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < EX_DEPTH; i++) begin
      if (CNT_W'(i) < count) busy[fifo_q[PTR_W'(rd_ptr + PTR_W'(i))].dr] = 1'b1;
    end
    if (enable_writeback) busy[dr] = 1'b1;
    if (mem_valid) busy[mem_dr] = 1'b1;
    stall = (sr1_use && busy[sr1]) || (sr2_use && busy[sr2]);
  end

  // Entry storage carries no reset; validity lives in count/pointers
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      streak <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (fifo_empty || ex_win)                              streak <= '0;
      else if (mem_win && streak != STK_W'(MAX_MEM_STREAK)) streak <= streak + STK_W'(1);
    end
  end

  // Writeback-stage output registers; operands hold when nothing wins
  always_ff @(posedge clock) begin
    if (reset) begin
      W_Control        <= 2'd0;
      aluout           <= 16'd0;
      pcout            <= 16'd0;
      npc              <= 16'd0;
      memout           <= 16'd0;
      enable_writeback <= 1'b0;
      dr               <= 3'd0;
    end else if (mem_win) begin
      W_Control        <= 2'd1;
      memout           <= mem_data;
      dr               <= mem_dr;
      enable_writeback <= 1'b1;
    end else if (ex_win) begin
      W_Control        <= (head.sel == 2'd1) ? 2'd0 : head.sel;
      aluout           <= head.aluout;
      pcout            <= head.pcout;
      npc              <= head.npc;
      dr               <= head.dr;
      enable_writeback <= 1'b1;
    end else if (bypass) begin
      W_Control        <= (ex_sel == 2'd1) ? 2'd0 : ex_sel;
      aluout           <= ex_aluout;
      pcout            <= ex_pcout;
      npc              <= ex_npc;
      dr               <= ex_dr;
      enable_writeback <= 1'b1;
    end else begin
      enable_writeback <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && ex_valid && ex_ready)
      assert (ex_sel != 2'd1) else $error("writeback_sched: illegal ex_sel=1 accepted");
  end
`endif

endmodule

// File: tb/tb_writeback_sched.sv
// Scoreboard bench for writeback_sched: per-class expected queues plus cycle-exact checks.
module tb_writeback_sched;

`ifdef WB_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [2:0]  dr;
  } ex_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dr;
  } mem_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_sel = 2'd0;
  logic [15:0] ex_aluout = 16'd0;
  logic [15:0] ex_pcout = 16'd0;
  logic [15:0] ex_npc = 16'd0;
  logic [2:0]  ex_dr = 3'd0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [15:0] mem_data = 16'd0;
  logic [2:0]  mem_dr = 3'd0;
  logic [2:0]  sr1 = 3'd0;
  logic [2:0]  sr2 = 3'd0;
  logic        sr1_use = 1'b0;
  logic        sr2_use = 1'b0;
  logic        stall;
  logic [1:0]  W_Control;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] npc;
  logic [15:0] memout;
  logic        enable_writeback;
  logic [2:0]  dr;

  writeback_sched dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_sel(ex_sel),
    .ex_aluout(ex_aluout), .ex_pcout(ex_pcout), .ex_npc(ex_npc), .ex_dr(ex_dr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_dr(mem_dr),
    .sr1(sr1), .sr2(sr2), .sr1_use(sr1_use), .sr2_use(sr2_use), .stall(stall),
    .W_Control(W_Control), .aluout(aluout), .pcout(pcout), .npc(npc), .memout(memout),
    .enable_writeback(enable_writeback), .dr(dr)
  );

  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic smp_ex_ready;
  logic smp_mem_ready;
  ex_t  ex_src[$];
  ex_t  exp_ex[$];
  mem_t mem_src[$];
  mem_t exp_mem[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: offer queue heads, record handshakes, return 1 unit after the edge
  task automatic cyc();
    ex_valid = (ex_src.size() != 0);
    if (ex_valid) begin
      ex_sel = ex_src[0].sel; ex_aluout = ex_src[0].alu; ex_pcout = ex_src[0].pc;
      ex_npc = ex_src[0].npc; ex_dr = ex_src[0].dr;
    end
    mem_valid = (mem_src.size() != 0);
    if (mem_valid) begin
      mem_data = mem_src[0].data; mem_dr = mem_src[0].dr;
    end
    @(negedge clock);
    smp_ex_ready  = ex_ready;
    smp_mem_ready = mem_ready;
    if (ex_valid && ex_ready) exp_ex.push_back(ex_src.pop_front());
    if (mem_valid && mem_ready) exp_mem.push_back(mem_src.pop_front());
    @(posedge clock);
    #1;
  endtask

  // Writeback monitor: each strobe retires the oldest expected result of its class
  always @(negedge clock) begin
    if (mon_en && enable_writeback) begin
      if (W_Control == 2'd1) begin
        if (exp_mem.size() == 0) check("wb_unexpected_load", 32'd1, 32'd0);
        else begin
          mem_t m;
          m = exp_mem.pop_front();
          check("wb_memout", 32'(memout), 32'(m.data));
          check("wb_mem_dr", 32'(dr), 32'(m.dr));
        end
      end else begin
        if (exp_ex.size() == 0) check("wb_unexpected_ex", 32'd1, 32'd0);
        else begin
          ex_t e;
          logic [15:0] want;
          e = exp_ex.pop_front();
          want = (e.sel == 2'd2) ? e.pc : (e.sel == 2'd3) ? e.npc : e.alu;
          check("wb_ex_wc", 32'(W_Control), 32'(e.sel));
          check("wb_ex_operand", 32'((W_Control == 2'd2) ? pcout : (W_Control == 2'd3) ? npc : aluout), 32'(want));
          check("wb_ex_dr", 32'(dr), 32'(e.dr));
        end
      end
    end
  end

  initial begin
    // Reset with two entries buffered behind loads
    repeat (2) cyc();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) ex_src.push_back('{sel: 2'd0, alu: 16'h0A00 + 16'(i), pc: 16'd0, npc: 16'd0, dr: 3'(i)});
    for (int i = 0; i < 3; i++) mem_src.push_back('{data: 16'h0B00 + 16'(i), dr: 3'd7});
    repeat (2) cyc();
    check("rst_fifo_full_before", 32'(ex_ready), 32'd0);
    ex_src.delete(); mem_src.delete();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_ex.delete(); exp_mem.delete();
    for (int c = 0; c < 2; c++) begin
      cyc();
      check("rst_no_wb", 32'(enable_writeback), 32'd0);
      check("rst_outputs_zero", 32'({W_Control, dr}) | 32'(aluout) | 32'(pcout) | 32'(npc) | 32'(memout), 32'd0);
      check("rst_ex_ready", 32'(ex_ready), 32'd1);
      check("rst_stall", 32'(stall), 32'd0);
    end
    mon_en = 1'b1;

    // Single execute result
    ex_src.push_back('{sel: 2'd0, alu: 16'h1234, pc: 16'h1111, npc: 16'h2222, dr: 3'd3});
    cyc();
    check("single_accept", 32'(smp_ex_ready), 32'd1);
    check("single_wb_n1", 32'(enable_writeback), 32'(BYP));
    cyc();
    check("single_wb_n2", 32'(enable_writeback), 32'(!BYP));
    check("single_aluout", 32'(aluout), 32'h1234);
    check("single_dr", 32'(dr), 32'd3);
    cyc();
    check("single_wb_once", 32'(enable_writeback), 32'd0);

    // Simultaneous load and execute: load first
    ex_src.push_back('{sel: 2'd3, alu: 16'h0, pc: 16'h0, npc: 16'h3001, dr: 3'd1});
    mem_src.push_back('{data: 16'hBEEF, dr: 3'd2});
    cyc();
    check("race_load_first_wc", 32'(W_Control), 32'd1);
    check("race_load_first_dr", 32'(dr), 32'd2);
    cyc();
    check("race_ex_next_wb", 32'(enable_writeback), 32'd1);
    check("race_ex_next_wc", 32'(W_Control), 32'd3);
    check("race_ex_next_npc", 32'(npc), 32'h3001);
    cyc();
    check("race_idle", 32'(enable_writeback), 32'd0);

    // Load streak limit with one execute pending
    ex_src.push_back('{sel: 2'd2, alu: 16'h0, pc: 16'hC0DE, npc: 16'h0, dr: 3'd4});
    for (int i = 0; i < 10; i++) mem_src.push_back('{data: 16'hA000 + 16'(i), dr: 3'(i)});
    for (int c = 0; c < 10; c++) begin
      cyc();
      check("streak_mem_ready", 32'(smp_mem_ready), (c == 5) ? 32'd0 : 32'd1);
      if (c == 5) check("streak_ex_wins", 32'(W_Control), 32'd2);
      else        check("streak_load_wins", 32'(W_Control), 32'd1);
    end
    repeat (4) cyc();

    // Back-to-back executes against a continuous load stream
    for (int i = 0; i < 3; i++) ex_src.push_back('{sel: 2'd0, alu: 16'h5000 + 16'(i), pc: 16'h0, npc: 16'h0, dr: 3'(4 + i)});
    for (int i = 0; i < 30; i++) mem_src.push_back('{data: 16'h6000 + 16'(i), dr: 3'd0});
    for (int c = 0; c < 40 && ex_src.size() != 0; c++) begin
      cyc();
      if (c < 2)       check("b2b_ex_ready_open", 32'(smp_ex_ready), 32'd1);
      else if (c == 2) check("b2b_ex_ready_full", 32'(smp_ex_ready), 32'd0);
    end
    check("b2b_all_accepted", 32'(ex_src.size()), 32'd0);
    mem_src.delete();
    repeat (6) cyc();

    // RAW hazard on a buffered destination
    ex_src.push_back('{sel: 2'd0, alu: 16'h0555, pc: 16'h0, npc: 16'h0, dr: 3'd5});
    mem_src.push_back('{data: 16'h4444, dr: 3'd0});
    cyc();
    sr1 = 3'd5; sr1_use = 1'b1; sr2 = 3'd7; sr2_use = 1'b0;
    #1 check("stall_fifo_dr", 32'(stall), 32'd1);
    sr1_use = 1'b0;
    #1 check("stall_unused_src", 32'(stall), 32'd0);
    sr1_use = 1'b1;
    cyc();
    check("stall_wb_strobe_dr", 32'(dr), 32'd5);
    check("stall_during_wb", 32'(stall), 32'd1);
    cyc();
    check("stall_cleared", 32'(stall), 32'd0);
    sr1_use = 1'b0; sr2 = 3'd6; sr2_use = 1'b1;
    mem_valid = 1'b1; mem_dr = 3'd6;
    #1 check("stall_mem_dr", 32'(stall), 32'd1);
    mem_src.push_back('{data: 16'h7777, dr: 3'd6});
    cyc();
    sr2_use = 1'b0;
    repeat (3) cyc();

    check("exp_ex_drained", 32'(exp_ex.size()), 32'd0);
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
